sync_fifo_unloader: RTL
=======================

// Module: sync_fifo_unloader
// PURPOSE
//  Read-side adapter placed directly downstream of sync_fifo. Pops the FIFO
//  through its rdreq/q/empty interface (q is registered, valid 1 cycle after
//  rdreq) and presents words on a valid/ready stream with a 2-entry output
//  buffer. The stream sustains 1 word/cycle and frames bursts via out_last.
//  Never issues rdreq to an empty FIFO, since sync_fifo does not guard underflow.
// PARAMETERS
//  WIDTH      32  data width; must equal the sync_fifo WIDTH
//  BURST_LEN  8   words per burst; out_last marks every BURST_LEN-th word (>=1)
//  BLOG2      3   width of the beat counter; 2**BLOG2 >= BURST_LEN, BLOG2 >= 1
// PORTS
//  clock        in   1      single clock, rising edge
//  sclr_n       in   1      synchronous, active-low reset
//  enable       in   1      1 = allow new FIFO pops; 0 = stop popping, drain buffer
//  fifo_q       in   WIDTH  sync_fifo q
//  fifo_empty   in   1      sync_fifo empty
//  fifo_rdreq   out  1      sync_fifo rdreq (combinational)
//  out_data     out  WIDTH  stream data
//  out_valid    out  1      stream valid
//  out_last     out  1      final word of the current burst, qualified by out_valid
//  out_ready    in   1      stream ready from the consumer
//  beat_cnt     out  BLOG2  index of the current word within its burst
//  busy         out  1      1 when the buffer holds data or a read is in flight
// BEHAVIOUR
//  Reset (sclr_n=0 at a clock edge): occupancy cnt=0, inflight=0, beat_cnt=0,
//   out_valid=0, out_last=0, busy=0, out_data=0. fifo_rdreq is forced to 0
//   while sclr_n=0. A reset during a transfer discards the buffered word and
//   any word in flight, with no partial-burst recovery.
//  Buffer: 2-entry circular store with 1-bit wr/rd pointers and a 2-bit cnt
//   (0..2). inflight is a 1-bit register equal to fifo_rdreq delayed by 1 cycle.
//  pop = out_valid & out_ready.
//  fifo_rdreq = sclr_n & enable & ~fifo_empty & ((cnt + inflight - pop) < 2).
//   This guarantees the buffer never overflows. Because fifo_empty is updated
//   registered, a pop of the last word makes empty=1 on the next cycle, so
//   back-to-back rdreq cannot underflow.
//  Capture: when inflight=1, fifo_q is written to entry wr_ptr at that edge
//   and wr_ptr toggles.
//  cnt_next = cnt + inflight - pop. A capture and a pop in the same cycle
//   leave cnt unchanged.
//  out_valid = (cnt != 0). out_data = entry at rd_ptr; rd_ptr toggles on pop.
//   out_data and out_last hold stable while out_valid=1 and out_ready=0.
//  Latency: with the buffer empty and fifo_empty falling in cycle t,
//   fifo_rdreq=1 in t, capture occurs at the end of t+1, and out_valid=1 in
//   t+2. Steady state with out_ready=1 and a non-empty FIFO: 1 word/cycle,
//   and fifo_rdreq stays high continuously.
//  Burst framing: out_last = out_valid & (beat_cnt == BURST_LEN-1).
//   On pop, beat_cnt becomes 0 if out_last, else beat_cnt+1.
//   With BURST_LEN=1, out_last = out_valid.
//  enable=0: no new rdreq. The in-flight word is still captured and buffered
//   words still drain. Re-asserting enable resumes without loss or duplication.
//  Ordering: words leave in exactly the order they are popped from the FIFO.
//   There is no drop and no duplication.
//  busy = (cnt != 0) | inflight.
// TESTING
//  1 Reset: sclr_n=0 for 2 cycles with fifo_empty=0 -> fifo_rdreq=0,
//    out_valid=0, beat_cnt=0. First rdreq occurs the cycle after sclr_n=1.
//  2 Streaming: write 16 words 0x0..0xF into a sync_fifo(DEPTH=8 ok by
//    refill), out_ready=1 -> out_data 0x0..0xF at 1 word/cycle, out_last on
//    0x7 and 0xF, first out_valid 2 cycles after the first rdreq.
//  3 Backpressure: 5 words queued, out_ready=0 -> at most 2 rdreq issued
//    (cnt=2, inflight=0), out_data=0x0 held stable. Release out_ready ->
//    remaining words arrive in order with no gaps beyond rdreq latency.
//  4 Underflow guard: exactly 1 word written, out_ready=1 -> exactly one rdreq
//    pulse; the sync_fifo usedw never wraps to all-ones. Random bursts of
//    writes and ready for 10k cycles -> rdreq never asserted while fifo_empty=1.
//  5 Enable/drain: deassert enable mid-stream after word 0x3 is popped ->
//    in-flight and buffered words (max 2) drain and busy falls to 0. Re-enable
//    -> the next word is 0x4+k with beat_cnt continuing.
//  6 Reset mid-burst: sclr_n=0 with cnt=2 and beat_cnt=5 -> next cycle
//    out_valid=0 and beat_cnt=0. The next delivered word has beat_cnt=0.

Source files
------------

// File: rtl/sync_fifo_unloader.sv
// Read-side adapter for sync_fifo: pops through rdreq/q/empty and presents the
// words on a valid/ready stream through a 2-entry buffer, framing bursts with out_last.
module sync_fifo_unloader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 8,
    parameter int BLOG2     = 3
) (
    input  logic             clock,
    input  logic             sclr_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [BLOG2-1:0] beat_cnt,
    output logic             busy
);

    localparam logic [BLOG2-1:0] LAST_BEAT = BLOG2'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BLOG2 < 1 || (1 << BLOG2) < BURST_LEN) begin : g_param_check
        $error("sync_fifo_unloader: BLOG2 too small for BURST_LEN");
    end

    logic [WIDTH-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             inflight;
    logic             pop;
    logic [1:0]       occ_next;

    assign pop = out_valid & out_ready;

    // occ_next counts the in-flight word as already owning a slot, so a new
    // read is only issued when a slot is guaranteed free when its data lands.
    // NOTE: fifo_rdreq depends combinationally on out_ready; keeping it out of
    // a register is what allows the stream to sustain one word per cycle.
    always_comb begin
        occ_next   = cnt + {1'b0, inflight} - {1'b0, pop};
        fifo_rdreq = sclr_n & enable & ~fifo_empty & (occ_next < 2'd2);
    end

    // NOTE: the two buffer entries are reset so out_data reads zero after reset;
    // all sequential state uses non-blocking assignments.
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            cnt        <= 2'd0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            beat_cnt   <= '0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            inflight <= fifo_rdreq;
            cnt      <= occ_next;
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_q;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= out_last ? '0 : beat_cnt + BLOG2'(1);
            end
        end
    end

    assign out_valid = (cnt != 2'd0);
    assign out_data  = buf_mem[rd_ptr];
    assign out_last  = out_valid & (beat_cnt == LAST_BEAT);
    assign busy      = out_valid | inflight;

endmodule
